// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared constants and FSM state type for the ula operation sequencer
package ula_pkg;
  localparam int OP_W    = 3;
  localparam int NOPS    = 8;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } state_t;
endpackage

// File: rtl/ula_op_pick.sv
// rtl/ula_op_pick.sv - next-op selector; honours op_mask when ULA_SEQ_MASK_EN is defined
module ula_op_pick
  import ula_pkg::*;
(
  input  logic [NOPS-1:0] mask,
  input  logic [OP_W-1:0] op,
  input  logic            incl,   // 1: op itself is a candidate (first-op search)
  output logic [OP_W-1:0] next,
  output logic            valid,
  output logic            last
);

`ifdef ULA_SEQ_MASK_EN
  // Lowest enabled op at or above the start point; last when nothing enabled lies above op.
  always_comb begin
    next  = '0;
    valid = 1'b0;
    last  = 1'b1;
    for (int i = NOPS - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(op)) || (incl && (i == int'(op))))) begin
        next  = OP_W'(i);
        valid = 1'b1;
      end
      if (mask[i] && (i > int'(op))) begin
        last = 1'b0;
      end
    end
  end
`else
  logic unused_mask;
  assign unused_mask = ^mask;

  // Plain ascending sweep over every op.
  always_comb begin
    next  = incl ? op : op + 1'b1;
    valid = incl | (op != OP_W'(NOPS - 1));
    last  = (op == OP_W'(NOPS - 1));
  end
`endif

endmodule

// File: rtl/ula_seq.sv
// rtl/ula_seq.sv - sweeps one operand pair through every ula op code; optional op_mask via ULA_SEQ_MASK_EN
module ula_seq
  import ula_pkg::*;
#(
  parameter int W   = 8,
  parameter int LAT = 1
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_a,
  input  logic [W-1:0]    in_b,
`ifdef ULA_SEQ_MASK_EN
  input  logic [NOPS-1:0] op_mask,
`endif
  output logic [W-1:0]    ula_a,
  output logic [W-1:0]    ula_b,
  output logic [OP_W-1:0] ula_op,
  input  logic [W-1:0]    ula_s,
  input  logic            ula_flag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] out_op,
  output logic [W-1:0]    out_s,
  output logic            out_flag,
  output logic            out_last,
  output logic            busy
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [NOPS-1:0]   mask_q;
  logic              any_q;      // command has at least one op to issue
  logic [NOPS-1:0]   mask_in;
  logic [OP_W-1:0]   first_op;
  logic              first_ok;
  logic              unused_first_last;
  logic [OP_W-1:0]   nxt_op;
  logic              nxt_last;
  logic              unused_nxt_valid;

`ifdef ULA_SEQ_MASK_EN
  assign mask_in = op_mask;
`else
  assign mask_in = '1;
`endif

  ula_op_pick u_pick_first (
    .mask  (mask_in),
    .op    ('0),
    .incl  (1'b1),
    .next  (first_op),
    .valid (first_ok),
    .last  (unused_first_last)
  );

  // The op being reported in HOLD is the one still on ula_op, so its successor drives the advance.
  ula_op_pick u_pick_next (
    .mask  (mask_q),
    .op    (out_op),
    .incl  (1'b0),
    .next  (nxt_op),
    .valid (unused_nxt_valid),
    .last  (nxt_last)
  );

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign out_last = (state_q == HOLD) && nxt_last;

  // State register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = WAIT;
      WAIT:    if (!any_q) state_d = IDLE;
               else if (cnt_q == '0) state_d = HOLD;
      HOLD:    if (out_valid && out_ready) state_d = nxt_last ? IDLE : WAIT;
      default: state_d = IDLE;
    endcase
  end

  // ALU drive, settle counter and result capture.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ula_a     <= '0;
      ula_b     <= '0;
      ula_op    <= '0;
      cnt_q     <= '0;
      mask_q    <= '0;
      any_q     <= 1'b0;
      out_valid <= 1'b0;
      out_op    <= '0;
      out_s     <= '0;
      out_flag  <= 1'b0;
    end else begin
      out_valid <= (state_d == HOLD);
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            ula_a  <= in_a;
            ula_b  <= in_b;
            ula_op <= first_op;
            cnt_q  <= CNT_W'(LAT);
            mask_q <= mask_in;
            any_q  <= first_ok;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            if (any_q) begin
              out_s    <= ula_s;
              out_flag <= ula_flag;
              out_op   <= ula_op;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            if (nxt_last) begin
              ula_op <= '0;
            end else begin
              ula_op <= nxt_op;
              cnt_q  <= CNT_W'(LAT);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
